fir_mc_reload: RTL

//  Multi-lane, time-multiplexed FIR filter with Avalon-ST sink/source handshakes (ready on both sides).

---
 rtl/fir_mc_reload_if.sv | 40 ++++
 rtl/fir_mc_reload.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fir_mc_reload_if.sv
// Streaming sink/source and coefficient-port bundle for fir_mc_reload.
// slave = the filter core, master = whoever drives it.
interface fir_mc_reload_if #(
    parameter int unsigned LANES  = 5,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned OUT_W  = 44,
    parameter int unsigned ADDR_W = 6
);
    logic [LANES*DATA_W-1:0] ast_sink_data;
    logic                    ast_sink_valid;
    logic                    ast_sink_ready;
    logic [1:0]              ast_sink_error;
    logic [LANES*OUT_W-1:0]  ast_source_data;
    logic                    ast_source_valid;
    logic                    ast_source_ready;
    logic [1:0]              ast_source_error;
    logic [ADDR_W-1:0]       coeff_in_address;
    logic                    coeff_in_we;
    logic [COEF_W-1:0]       coeff_in_data;
    logic                    coeff_in_read;
    logic                    coeff_out_valid;
    logic [COEF_W-1:0]       coeff_out_data;
    logic                    coeff_swap;
    logic                    coeff_pending;

    modport slave (
        input  ast_sink_data, ast_sink_valid, ast_sink_error, ast_source_ready,
        input  coeff_in_address, coeff_in_we, coeff_in_data, coeff_in_read, coeff_swap,
        output ast_sink_ready, ast_source_data, ast_source_valid, ast_source_error,
        output coeff_out_valid, coeff_out_data, coeff_pending
    );

    modport master (
        output ast_sink_data, ast_sink_valid, ast_sink_error, ast_source_ready,
        output coeff_in_address, coeff_in_we, coeff_in_data, coeff_in_read, coeff_swap,
        input  ast_sink_ready, ast_source_data, ast_source_valid, ast_source_error,
        input  coeff_out_valid, coeff_out_data, coeff_pending
    );
endinterface

// File: rtl/fir_mc_reload.sv
// Multi-lane time-multiplexed FIR: one tap per cycle across all lanes, with a
// double-buffered coefficient set committed only between samples.
module fir_mc_reload #(
    parameter int unsigned LANES  = 5,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned TAPS   = 32,
    parameter int unsigned OUT_W  = 44,
    parameter int unsigned ADDR_W = 6
) (
    input logic            clk,
    input logic            reset_n,
    fir_mc_reload_if.slave bus
);
    localparam int unsigned KW = $clog2(TAPS);
    localparam int unsigned PW = DATA_W + COEF_W;

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    state_e state_q, state_d;

    logic [KW-1:0]            k_q;
    logic signed [DATA_W-1:0] x_q      [LANES][TAPS];
    logic signed [COEF_W-1:0] shadow_q [TAPS];
    logic signed [COEF_W-1:0] active_q [TAPS];
    logic signed [OUT_W-1:0]  acc_q    [LANES];
    logic signed [OUT_W-1:0]  acc_d    [LANES];
    logic signed [PW-1:0]     prod     [LANES];
    logic [1:0]               err_q;
    logic                     pending_q, pending_d;
    logic                     coeff_out_valid_q;
    logic [COEF_W-1:0]        coeff_out_data_q;

    logic          sink_ready;
    logic          accept;
    logic          commit;
    logic          mac_last;
    logic          addr_ok;
    logic [KW-1:0] addr_idx;

    assign addr_ok  = (32'(bus.coeff_in_address) < TAPS);
    assign addr_idx = bus.coeff_in_address[KW-1:0];
    assign mac_last = (k_q == KW'(TAPS - 1));

    // FSM next state, sink handshake and commit decision.
    always_comb begin
        state_d    = state_q;
        sink_ready = 1'b0;
        commit     = 1'b0;
        accept     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A commit cycle refuses the sink so the new bank lands before the next sample.
                commit     = pending_q;
                sink_ready = reset_n && !pending_q;
                accept     = bus.ast_sink_valid && sink_ready;
                if (accept) state_d = StMac;
            end
            StMac: begin
                if (mac_last) state_d = StOut;
            end
            StOut: begin
                if (bus.ast_source_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Swap request: re-armed by a swap arriving on the commit cycle itself.
    always_comb begin
        pending_d = commit ? bus.coeff_swap : (pending_q | bus.coeff_swap);
    end

    // FSM state register and control counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
            k_q       <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (accept) begin
                k_q   <= '0;
                err_q <= bus.ast_sink_error;
            end else if (state_q == StMac) begin
                k_q <= k_q + KW'(1);
            end
        end
    end

    // One tap per lane: sign-extended product added with wrap-around.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            prod[l]  = PW'(x_q[l][k_q]) * PW'(active_q[k_q]);
            acc_d[l] = acc_q[l] + OUT_W'(prod[l]);
        end
    end

    // Delay lines and accumulators.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= '0;
                for (int k = 0; k < TAPS; k++) x_q[l][k] <= '0;
            end
        end else if (accept) begin
            for (int l = 0; l < LANES; l++) begin
                acc_q[l]  <= '0;
                x_q[l][0] <= bus.ast_sink_data[l*DATA_W +: DATA_W];
                for (int k = 1; k < TAPS; k++) x_q[l][k] <= x_q[l][k-1];
            end
        end else if (state_q == StMac) begin
            for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
        end
    end

    // Coefficient banks; commit copies the pre-edge shadow contents.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < TAPS; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            if (commit) begin
                for (int k = 0; k < TAPS; k++) active_q[k] <= shadow_q[k];
            end
            if (bus.coeff_in_we && addr_ok) shadow_q[addr_idx] <= bus.coeff_in_data;
        end
    end

    // Shadow readback, one cycle after the request; returns the pre-write value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            coeff_out_valid_q <= 1'b0;
            coeff_out_data_q  <= '0;
        end else begin
            coeff_out_valid_q <= bus.coeff_in_read;
            coeff_out_data_q  <= (bus.coeff_in_read && addr_ok) ? shadow_q[addr_idx] : '0;
        end
    end

    // Output drive: result and tag only presented while in OUT.
    always_comb begin
        bus.ast_source_data = '0;
        if (state_q == StOut) begin
            for (int l = 0; l < LANES; l++) bus.ast_source_data[l*OUT_W +: OUT_W] = acc_q[l];
        end
    end

    assign bus.ast_sink_ready   = sink_ready;
    assign bus.ast_source_valid = (state_q == StOut);
    assign bus.ast_source_error = (state_q == StOut) ? err_q : 2'b00;
    assign bus.coeff_out_valid  = coeff_out_valid_q;
    assign bus.coeff_out_data   = coeff_out_data_q;
    assign bus.coeff_pending    = pending_q;
endmodule
